// File: rtl/lcd_inst_pkg.sv
// Shared HD44780-style instruction constants, controller state encoding,
// power-up command table and the latched transfer payload.
package lcd_inst_pkg;

  localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME       = 8'h02;
  localparam logic [7:0] LCD_CMD_HOME_ALT   = 8'h03;
  localparam logic [7:0] LCD_CMD_ENTRY_INC  = 8'h06;
  localparam logic [7:0] LCD_CMD_DISPLAY_ON = 8'h0C;
  localparam logic [7:0] LCD_CMD_FUNC_8BIT  = 8'h38;

  localparam int unsigned INIT_LEN = 4;

  // Entry [0] is issued first.
  localparam logic [INIT_LEN-1:0][7:0] INIT_TABLE = {
    LCD_CMD_ENTRY_INC, LCD_CMD_CLEAR, LCD_CMD_DISPLAY_ON, LCD_CMD_FUNC_8BIT
  };

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    SETUP,
    PULSE,
    HOLD,
    EXEC_WAIT,
    IDLE
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_xfer_t;

  // Clear and return-home need the long execution wait.
  function automatic logic is_long_cmd(input lcd_xfer_t x);
    return !x.rs && ((x.data == LCD_CMD_CLEAR) || (x.data == LCD_CMD_HOME) ||
                     (x.data == LCD_CMD_HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter: a load of N makes o_done_c rise N-1 cycles later,
// so a state entered with the load lasts exactly N cycles.
module lcd_cycle_timer #(
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned RST_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_cycles,
  output logic             o_done_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= CNT_W'(RST_CYCLES - 1);
    end else if (i_load) begin
      r_cnt <= i_cycles - CNT_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/lcd_mm_slave.sv
// Memory-mapped slave that drives a character LCD in 8-bit write-only mode:
// runs the power-up init, then forwards each bus write as one timed EN strobe.
module lcd_mm_slave
  import lcd_inst_pkg::*;
#(
  parameter int unsigned T_POWERUP = 1_000_000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_EN      = 16,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_EXEC    = 2000,
  parameter int unsigned T_CLEAR   = 82000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       address,
  input  logic       chipselect,
  input  logic       byteenable,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic [1:0] response,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on
);

  localparam int unsigned CNT_W = 20;

  lcd_state_e       r_state;
  lcd_xfer_t        r_xfer;
  logic             r_en;
  logic [2:0]       r_init_idx;

  logic             w_busy;
  logic             w_rd;
  logic             w_wr_accept;
  logic             w_done;
  logic             w_load;
  logic             w_init_more;
  logic [CNT_W-1:0] w_load_cycles;
  logic [CNT_W-1:0] w_exec_cycles;
  logic             w_unused;

  assign w_unused    = byteenable;
  assign w_busy      = (r_state != IDLE);
  assign w_rd        = chipselect & read;
  assign w_wr_accept = (r_state == IDLE) & chipselect & write;
  assign w_init_more = (r_init_idx < 3'(INIT_LEN));
  assign w_exec_cycles = is_long_cmd(r_xfer) ? CNT_W'(T_CLEAR) : CNT_W'(T_EXEC);

  assign waitrequest = w_busy & ~w_rd;
  assign readdata    = w_rd ? {w_busy, 7'b0} : 8'h00;
  assign response    = 2'b00;
  assign lcd_rw      = 1'b0;
  assign lcd_on      = 1'b1;
  assign lcd_data    = r_xfer.data;
  assign lcd_rs      = r_xfer.rs;
  assign lcd_en      = r_en;

  // Reload the timer with the duration of the state being entered.
  always_comb begin
    w_load        = 1'b0;
    w_load_cycles = CNT_W'(1);
    case (r_state)
      PWR_WAIT:  begin w_load = w_done;      w_load_cycles = CNT_W'(1);       end
      INIT:      begin w_load = w_done;      w_load_cycles = CNT_W'(T_SETUP); end
      SETUP:     begin w_load = w_done;      w_load_cycles = CNT_W'(T_EN);    end
      PULSE:     begin w_load = w_done;      w_load_cycles = CNT_W'(T_HOLD);  end
      HOLD:      begin w_load = w_done;      w_load_cycles = w_exec_cycles;   end
      EXEC_WAIT: begin w_load = w_done;      w_load_cycles = CNT_W'(1);       end
      IDLE:      begin w_load = w_wr_accept; w_load_cycles = CNT_W'(T_SETUP); end
      default:   ;
    endcase
  end

  lcd_cycle_timer #(
    .CNT_W     (CNT_W),
    .RST_CYCLES(T_POWERUP)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_cycles(w_load_cycles),
    .o_done_c(w_done)
  );

  // Controller FSM; EN is set on entry to PULSE and cleared on exit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= PWR_WAIT;
      r_init_idx <= '0;
      r_en       <= 1'b0;
      r_xfer     <= '0;
    end else begin
      case (r_state)
        PWR_WAIT: begin
          if (w_done) begin
            r_state    <= INIT;
            r_init_idx <= '0;
          end
        end
        INIT: begin
          if (w_done) begin
            r_xfer.rs   <= 1'b0;
            r_xfer.data <= INIT_TABLE[r_init_idx[1:0]];
            r_init_idx  <= r_init_idx + 3'd1;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          if (w_done) begin
            r_state <= PULSE;
            r_en    <= 1'b1;
          end
        end
        PULSE: begin
          if (w_done) begin
            r_state <= HOLD;
            r_en    <= 1'b0;
          end
        end
        HOLD: begin
          if (w_done) r_state <= EXEC_WAIT;
        end
        EXEC_WAIT: begin
          if (w_done) r_state <= w_init_more ? INIT : IDLE;
        end
        IDLE: begin
          if (w_wr_accept) begin
            r_xfer.rs   <= address;
            r_xfer.data <= writedata;
            r_state     <= SETUP;
          end
        end
        default: begin
          r_state <= PWR_WAIT;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_mm_slave.sv
// Directed bench for lcd_mm_slave: an LCD model pops expected {rs,data}
// entries from a scoreboard on each EN rising edge.
module tb_lcd_mm_slave;

  localparam int T_PU = 20;
  localparam int T_S  = 2;
  localparam int T_E  = 4;
  localparam int T_H  = 2;
  localparam int T_X  = 10;
  localparam int T_C  = 40;
  localparam int BUSY_SHORT = T_S + T_E + T_H + T_X;
  localparam int BUSY_CLR   = T_S + T_E + T_H + T_C;
  localparam int INIT_TOTAL = T_PU + 4 * (1 + T_S + T_E + T_H) + 3 * T_X + T_C;
  localparam int BUDGET     = 5000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       address = 1'b0;
  logic       chipselect = 1'b0;
  logic       byteenable = 1'b1;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [7:0] writedata = 8'h00;
  logic [7:0] readdata;
  logic       waitrequest;
  logic [1:0] response;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;

  int n_vec  = 0;
  int n_fail = 0;
  logic [8:0] sb[$];
  logic abort_pulse = 1'b0;

  always #5 clk = ~clk;

  lcd_mm_slave #(
    .T_POWERUP(T_PU), .T_SETUP(T_S), .T_EN(T_E),
    .T_HOLD(T_H), .T_EXEC(T_X), .T_CLEAR(T_C)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .waitrequest(waitrequest), .response(response),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_on(lcd_on)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_init();
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h06});
  endtask

  // Holds a write until accepted; returns the number of stalled cycles.
  task automatic bus_write(input logic a, input logic [7:0] d, output int stalls);
    stalls = 0;
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    #1;
    while (waitrequest === 1'b1 && stalls < BUDGET) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stalls >= BUDGET) check("write_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  // Counts busy cycles starting with the current one.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    #1;
    while (waitrequest === 1'b1 && cycles < BUDGET) begin
      cycles++;
      @(negedge clk); #1;
    end
    if (cycles >= BUDGET) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // LCD model: capture on EN rise, check pulse width on EN fall.
  logic prev_en = 1'b0;
  int   hi_cnt  = 0;
  always @(negedge clk) begin
    if (lcd_en === 1'b1 && prev_en === 1'b0) begin
      if (sb.size() == 0) begin
        check("lcd_unexpected_pulse", {23'b0, lcd_rs, lcd_data}, 32'h1FF);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("lcd_capture", {23'b0, lcd_rs, lcd_data}, {23'b0, e});
      end
      check("lcd_rw_on", {30'b0, lcd_rw, lcd_on}, 32'd1);
      hi_cnt = 1;
    end else if (lcd_en === 1'b1) begin
      hi_cnt++;
    end
    if (lcd_en === 1'b0 && prev_en === 1'b1) begin
      if (!abort_pulse) check("lcd_en_width", 32'(hi_cnt), 32'(T_E));
      abort_pulse = 1'b0;
    end
    prev_en = lcd_en;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int    st;
    int    cyc;
    string msg;
    msg = "HELLO FPGA MENU";

    // Power-up from reset
    repeat (3) @(negedge clk);
    #1;
    check("rst_lcd_en", 32'(lcd_en), 32'd0);
    check("rst_lcd_rs", 32'(lcd_rs), 32'd0);
    check("rst_lcd_data", 32'(lcd_data), 32'h00);
    check("rst_waitrequest", 32'(waitrequest), 32'd1);
    check("rst_response", 32'(response), 32'd0);
    push_init();
    reset_n = 1'b1;
    wait_idle(cyc);
    check("init_busy_cycles", 32'(cyc), 32'(INIT_TOTAL));
    check("init_sb_drained", 32'(sb.size()), 32'd0);

    // Read in IDLE
    chipselect = 1'b1; read = 1'b1; #1;
    check("idle_readdata", 32'(readdata), 32'h00);
    check("idle_read_wait", 32'(waitrequest), 32'd0);
    chipselect = 1'b0; read = 1'b0;

    // Single data write
    sb.push_back({1'b1, 8'h48});
    bus_write(1'b1, 8'h48, st);
    check("wr48_stalls", 32'(st), 32'd0);
    @(negedge clk);
    wait_idle(cyc);
    check("wr48_busy", 32'(cyc), 32'(BUSY_SHORT));
    check("wr48_lcd_bus", {23'b0, lcd_rs, lcd_data}, {23'b0, 1'b1, 8'h48});

    // Read during EXEC_WAIT
    sb.push_back({1'b1, 8'h41});
    bus_write(1'b1, 8'h41, st);
    repeat (T_S + T_E + T_H + 1) @(negedge clk);
    chipselect = 1'b1; read = 1'b1; #1;
    check("exec_readdata", 32'(readdata), 32'h80);
    check("exec_read_wait", 32'(waitrequest), 32'd0);
    check("exec_response", 32'(response), 32'd0);
    chipselect = 1'b0; read = 1'b0;
    wait_idle(cyc);
    check("exec_remaining", 32'(cyc), 32'(T_X));

    // Clear followed by a held write
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b1, 8'h45});
    bus_write(1'b0, 8'h01, st);
    bus_write(1'b1, 8'h45, st);
    check("stall_after_clear", 32'(st), 32'(BUSY_CLR));
    @(negedge clk);
    wait_idle(cyc);
    check("wr45_busy", 32'(cyc), 32'(BUSY_SHORT));

    // Simultaneous read and write in IDLE
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 1'b1; writedata = 8'h4C;
    sb.push_back({1'b1, 8'h4C});
    #1;
    check("rw_waitrequest", 32'(waitrequest), 32'd0);
    check("rw_readdata", 32'(readdata), 32'h00);
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    check("rw_response", 32'(response), 32'd0);
    @(negedge clk);
    wait_idle(cyc);
    check("rw_busy", 32'(cyc), 32'(BUSY_SHORT));

    // Reset in the middle of an EN pulse
    sb.push_back({1'b1, 8'h5A});
    bus_write(1'b1, 8'h5A, st);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (lcd_en !== 1'b1 && cyc < BUDGET);
    if (cyc >= BUDGET) check("pulse_timeout", 32'd1, 32'd0);
    @(negedge clk);
    abort_pulse = 1'b1;
    reset_n = 1'b0;
    @(negedge clk); #1;
    check("rst_pulse_en", 32'(lcd_en), 32'd0);
    check("rst_pulse_wait", 32'(waitrequest), 32'd1);
    check("rst_pulse_bus", {23'b0, lcd_rs, lcd_data}, 32'd0);
    push_init();
    reset_n = 1'b1;
    wait_idle(cyc);
    check("reinit_busy_cycles", 32'(cyc - 1), 32'(INIT_TOTAL - 1));
    check("reinit_sb_drained", 32'(sb.size()), 32'd0);

    // Menu writer: clear then 15 characters, back to back
    sb.push_back({1'b0, 8'h01});
    bus_write(1'b0, 8'h01, st);
    check("menu_clear_stall", 32'(st), 32'd0);
    for (int i = 0; i < 15; i++) begin
      sb.push_back({1'b1, 8'(msg[i])});
      bus_write(1'b1, 8'(msg[i]), st);
      check("menu_char_stall", 32'(st), (i == 0) ? 32'(BUSY_CLR) : 32'(BUSY_SHORT));
    end
    @(negedge clk);
    wait_idle(cyc);
    check("menu_last_busy", 32'(cyc), 32'(BUSY_SHORT));
    repeat (2) @(negedge clk);
    check("menu_sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
